noc_memory_responder: RTL
=========================

# noc_memory_responder

NOC endpoint that serves `memory_write_request` and `memory_read_request` packets from core-side initiators such as the program flow control unit, which uses them for stack push and pop. It sits at NOC address 2, port 0. It accepts one request at a time, performs a 32-bit word access on a local synchronous RAM, and returns the matching reply packet to the requester. This is the responder end of the memory request/reply protocol.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two.
- `IDX_W`, $clog2(DEPTH_WORDS): word-index width (derived).

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on `clk`; 0 = reset).
- `noc_port`  inout  ip_port  NOC endpoint. Uses `dat_from_noc`, `rx_recieve`, `rx_complete`, `dat_to_noc`, `tx_submit`, `tx_complete`, `to_noc_prt_stat`, `port_address`, `port_number`.
- `busy`  out  1  high in every state except IDLE.
- `drop_count`  out  8  saturating count of consumed packets whose type is not a memory request.

## Operation
- Address decode:
  - Request byte address is `dat[31:0]`.
  - Word index is `dat[IDX_W+1:2]`.
  - `dat[1:0]` and the bits above `IDX_W+1` are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- Write request: `dat[63:32]` is written to the indexed word.
- Read request: the indexed word is returned in the reply.
- State machine:
  - IDLE → ACCEPT when `rx_recieve`=1. The request packet is latched into a capture register on that edge.
  - ACCEPT:
    - `rx_complete`=1 for exactly this one cycle.
    - RAM enable is asserted: write commits at the end of ACCEPT; a read is issued.
    - Next state: write → SEND; read → RDWAIT; any other `pt` → IDLE with `drop_count`+1, saturating at 255.
  - RDWAIT: RAM read data is registered into the reply; → SEND.
  - SEND:
    - `tx_submit`=1 and `dat_to_noc` is held stable.
    - Accepted on a cycle where `to_noc_prt_stat==port_open && tx_complete`; the next state is IDLE.
    - Otherwise stays in SEND indefinitely. There is no timeout.
- Reply packet, all fields registered:
  - Routing: `dst_addr`=req `src_addr`, `dst_prt`=req `src_prt`, `src_addr`=`port_address`, `src_prt`=`port_number`, `id`=req `id`.
  - Write reply: `pt`=`memory_write_reply`, `dat[31:0]`=req address, `dat[63:32]`=data written, `dat[127:64]`=0.
  - Read reply: `pt`=`memory_read_reply`, `dat[31:0]`=RAM word, `dat[127:32]`=0.
- `rx_recieve` is ignored outside IDLE. No `rx_complete` is issued and the packet stays pending in the NOC.
- Back-to-back requests: a request pending in the cycle IDLE is re-entered is captured on that edge. There is no dead cycle beyond IDLE itself.

## Timing
- Reset (`rst`=0 at an edge):
  - State goes to IDLE.
  - `rx_complete`=0, `tx_submit`=0, `dat_to_noc`=0, `busy`=0, `drop_count`=0.
  - RAM contents are not cleared.
- Reset mid-operation from any state:
  - Outputs are deasserted in the cycle after the reset edge.
  - An in-flight reply is abandoned.
  - A write whose ACCEPT cycle completed stays committed.
- Let edge E0 be the edge where `rx_recieve` is sampled in IDLE. Then:
  - `rx_complete` is high during cycle E0→E1.
  - Write: `tx_submit` rises after E1, so request-to-submit latency is 2 cycles.
  - Read: `tx_submit` rises after E2, so latency is 3 cycles.
  - Minimum turnaround per request is 3 cycles (write) or 4 cycles (read) with immediate acceptance.
- Read-after-write: a read captured after a write to the same word returns the new data. The write commits in ACCEPT, before any later RAM read.
- `tx_submit` and `dat_to_noc` change only on state entry or exit, never while waiting in SEND.

## Structure
- Shared package (`structs.sv`) provides `packet`, `ip_port`, the packet-type enum and `port_open`.
- Add to the package:
  - the `resp_state_t` enum: IDLE, ACCEPT, RDWAIT, SEND;
  - the constants `MEM_ADDR_LSB=0`, `MEM_WDATA_LSB=32`, `MEM_RDATA_LSB=0`, so initiators and responder share field offsets.
- One sub-module, `mem_word_array`: single-port synchronous RAM, `DEPTH_WORDS`×32, with inputs `en`, `we`, `idx` and `wdata`, and `rdata` valid one cycle after `en`.

## Test plan
- Write then read: write request at address 0x0000_0FFC, data 0xDEAD_BEEF, src 5/1, id 3. Expect a write reply to 5/1 with id 3 and dat[31:0]=0x0FFC. A subsequent read of 0x0FFC returns 0xDEAD_BEEF, with submit latency 2 and 3 cycles respectively.
- Wrap: with DEPTH_WORDS=1024, write 0x1111_1111 to 0x0000_0004, then read 0x0000_1004 and 0x0000_0007. Both return 0x1111_1111.
- Backpressure: hold `tx_complete`=0 for 10 cycles in SEND. `tx_submit` and `dat_to_noc` stay constant, and a second `rx_recieve` gets no `rx_complete` until the reply is accepted.
- Drop: send a `memory_read_reply`-type packet. Expect `rx_complete` pulse, no tx, `drop_count`=1. After 300 such packets `drop_count` saturates at 255.
- Reset mid-SEND: assert `rst`=0 for one edge while `tx_submit`=1. Next cycle all outputs are 0 and state is IDLE; a following read of the prior write address returns the written data.
- Back-to-back: keep `rx_recieve` high with two queued writes. Expect two `rx_complete` pulses 3 cycles apart and two replies in order.

Source files
------------

// File: rtl/noc_memory_responder_pkg.sv
// Shared NOC packet types plus the memory request/reply field offsets and
// responder state encoding used by initiators and the memory responder.
package noc_memory_responder_pkg;

  localparam int ADDR_W = 4;
  localparam int PRT_W  = 2;
  localparam int ID_W   = 8;
  localparam int DAT_W  = 128;

  typedef enum logic [3:0] {
    unknown_packet       = 4'h0,
    memory_write_request = 4'h1,
    memory_read_request  = 4'h2,
    memory_write_reply   = 4'h3,
    memory_read_reply    = 4'h4
  } pkt_type_t;

  typedef enum logic {
    port_closed = 1'b0,
    port_open   = 1'b1
  } port_stat_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dst_addr;
    logic [PRT_W-1:0]  dst_prt;
    logic [ADDR_W-1:0] src_addr;
    logic [PRT_W-1:0]  src_prt;
    logic [ID_W-1:0]   id;
    pkt_type_t         pt;
    logic [DAT_W-1:0]  dat;
  } packet;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    RDWAIT = 2'd2,
    SEND   = 2'd3
  } resp_state_t;

  localparam int MEM_ADDR_LSB  = 0;
  localparam int MEM_WDATA_LSB = 32;
  localparam int MEM_RDATA_LSB = 0;

endpackage

// File: rtl/noc_memory_responder_if.sv
// NOC endpoint port: slave is the endpoint side, master is the network side.
interface ip_port;
  import noc_memory_responder_pkg::*;

  packet             dat_from_noc;
  logic              rx_recieve;
  logic              rx_complete;
  packet             dat_to_noc;
  logic              tx_submit;
  logic              tx_complete;
  port_stat_t        to_noc_prt_stat;
  logic [ADDR_W-1:0] port_address;
  logic [PRT_W-1:0]  port_number;

  modport slave (
    input  dat_from_noc, rx_recieve, tx_complete, to_noc_prt_stat,
           port_address, port_number,
    output rx_complete, dat_to_noc, tx_submit
  );

  modport master (
    output dat_from_noc, rx_recieve, tx_complete, to_noc_prt_stat,
           port_address, port_number,
    input  rx_complete, dat_to_noc, tx_submit
  );

endinterface

// File: rtl/noc_memory_responder_mem.sv
// Single-port synchronous word RAM; rdata is valid the cycle after en (read-first).
module mem_word_array
  import noc_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/noc_memory_responder.sv
// NOC memory responder: serves one memory read/write request at a time from a
// local word RAM and returns the matching reply to the requester.
//   state  | meaning
//   IDLE   | waiting for a pending packet; captures it on rx_recieve
//   ACCEPT | rx_complete pulse; RAM write commits or read issues
//   RDWAIT | RAM read data registered into the reply
//   SEND   | reply offered with tx_submit until the NOC accepts it
module noc_memory_responder
  import noc_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  ip_port.slave       noc_port,
  output logic        busy,
  output logic [7:0]  drop_count
);

  resp_state_t state, state_nx;
  packet       req_q, reply_q, reply_nx;
  logic        capture, rx_complete_c, ram_en, ram_we, load_reply, drop_inc;
  logic        is_wr, is_rd, tx_accept;
  logic [31:0] ram_rdata;
  logic        unused_req;

  assign is_wr     = (req_q.pt == memory_write_request);
  assign is_rd     = (req_q.pt == memory_read_request);
  assign tx_accept = (noc_port.to_noc_prt_stat == port_open) && noc_port.tx_complete;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    capture       = 1'b0;
    rx_complete_c = 1'b0;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    load_reply    = 1'b0;
    drop_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (noc_port.rx_recieve) begin
          capture  = 1'b1;
          state_nx = ACCEPT;
        end
      end
      ACCEPT: begin
        rx_complete_c = 1'b1;
        if (is_wr) begin
          ram_en     = 1'b1;
          ram_we     = 1'b1;
          load_reply = 1'b1;
          state_nx   = SEND;
        end else if (is_rd) begin
          ram_en   = 1'b1;
          state_nx = RDWAIT;
        end else begin
          drop_inc = 1'b1;
          state_nx = IDLE;
        end
      end
      RDWAIT: begin
        load_reply = 1'b1;
        state_nx   = SEND;
      end
      SEND: begin
        if (tx_accept) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    reply_nx          = '0;
    reply_nx.dst_addr = req_q.src_addr;
    reply_nx.dst_prt  = req_q.src_prt;
    reply_nx.src_addr = noc_port.port_address;
    reply_nx.src_prt  = noc_port.port_number;
    reply_nx.id       = req_q.id;
    if (is_rd) begin
      reply_nx.pt                         = memory_read_reply;
      reply_nx.dat[MEM_RDATA_LSB +: 32]   = ram_rdata;
    end else begin
      reply_nx.pt                         = memory_write_reply;
      reply_nx.dat[MEM_ADDR_LSB +: 32]    = req_q.dat[MEM_ADDR_LSB +: 32];
      reply_nx.dat[MEM_WDATA_LSB +: 32]   = req_q.dat[MEM_WDATA_LSB +: 32];
    end
  end

  // Capture register is not reset: it is only consumed after a fresh capture.
  always_ff @(posedge clk) begin
    if (capture) req_q <= noc_port.dat_from_noc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reply_q    <= '0;
      drop_count <= '0;
    end else begin
      if (load_reply) reply_q <= reply_nx;
      if (drop_inc && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (req_q.dat[MEM_ADDR_LSB + IDX_W + 1 : MEM_ADDR_LSB + 2]),
    .wdata (req_q.dat[MEM_WDATA_LSB +: 32]),
    .rdata (ram_rdata)
  );

  assign noc_port.rx_complete = rx_complete_c;
  assign noc_port.tx_submit   = (state == SEND);
  assign noc_port.dat_to_noc  = reply_q;
  assign busy                 = (state != IDLE);

  // Routing to us is done by the NOC; the upper payload of a request is unused.
  assign unused_req = ^{req_q.dst_addr, req_q.dst_prt, req_q.dat[DAT_W-1:64]};

endmodule
